bin2bcd_sequencer: RTL and testbench

BIN2BCD_SEQUENCER -- requirements
Module: bin2bcd_sequencer

---
 rtl/bin2bcd_sequencer.sv | 132 +++++++++++++
 tb/tb_bin2bcd_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_sequencer.sv
// bin2bcd_sequencer
//   Sequential binary-to-BCD converter (double dabble), one bit per clock.
//   An operand is accepted on inValid&inReady. The block then runs binWidth
//   shift steps and holds the result until outValid&outReady.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   rst       : synchronous active-high reset
//   binIn     : binary operand, sampled on the input handshake
//   inValid   : requester offers binIn
//   inReady   : block can accept an operand (IDLE only)
//   digitOut  : BCD result, digit 0 in [3:0]; reflects the BCD register at all times
//   overflow  : operand was >= 10^numberOfDigits
//   outValid  : digitOut/overflow valid (DONE only)
//   outReady  : consumer takes the result
//   busy      : conversion in progress or result pending
module bin2bcd_sequencer #(
  parameter int numberOfDigits = 3,
  parameter int binWidth       = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [binWidth-1:0]         binIn,
  input  logic                        inValid,
  output logic                        inReady,
  output logic [4*numberOfDigits-1:0] digitOut,
  output logic                        overflow,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        busy
);

  localparam int          BW = 4 * numberOfDigits;
  localparam int          CW = $clog2(binWidth + 1);
  localparam int unsigned ND = numberOfDigits;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q;
  logic [BW-1:0]       bcd_q;
  logic [binWidth-1:0] bin_q;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q;
  logic                inReady_q;
  logic                outValid_q;
  logic                busy_q;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       bcd_d;
  logic [binWidth-1:0] bin_d;
  logic [CW-1:0]       cnt_d;
  logic                carry_d;

  // One double-dabble step: correct every digit in parallel, then shift.
  // The bit leaving the top digit would belong to a digit we do not keep,
  // so it only feeds the sticky overflow flag.
  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < ND; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d   = {adj[BW-2:0], bin_q[binWidth-1]};
    carry_d = adj[BW-1];
    bin_d   = bin_q << 1;
    cnt_d   = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // inReady_q is always 1 here, so inValid alone completes the handshake
          if (inValid) begin
            bin_q     <= binIn;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CW'(binWidth);
            state_q   <= SHIFT;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          ovf_q <= ovf_q | carry_d;
          cnt_q <= cnt_d;
          if (cnt_q == CW'(1)) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (outReady) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign inReady  = inReady_q;
  assign outValid = outValid_q;
  assign busy     = busy_q;
  assign digitOut = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_sequencer.sv
module tb_bin2bcd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  binIn;
  logic        inValid;
  logic        inReady;
  logic [11:0] digitOut;
  logic        overflow;
  logic        outValid;
  logic        outReady;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_in     = 0;
  int n_out    = 0;

  bin2bcd_sequencer #(
    .numberOfDigits(3),
    .binWidth      (10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .binIn   (binIn),
    .inValid (inValid),
    .inReady (inReady),
    .digitOut(digitOut),
    .overflow(overflow),
    .outValid(outValid),
    .outReady(outReady),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Handshake monitor for the lost/duplicated transaction check
  always @(posedge clk) begin
    if (!rst) begin
      if (inValid && inReady)   n_in  <= n_in + 1;
      if (outValid && outReady) n_out <= n_out + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int unsigned v);
    int unsigned r;
    r = v % 1000;
    return {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers v, waits for acceptance, then waits for outValid.
  // lat counts the handshake cycle as cycle 1.
  task automatic convert(input logic [9:0] v, output int lat);
    bit got;
    binIn   = v;
    inValid = 1'b1;
    got     = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (inReady) got = 1'b1;
      tick();
      if (got) break;
    end
    check_eq("accept_timeout", 32'(got), 32'd1);
    inValid = 1'b0;
    binIn   = ~v;
    lat     = 1;
    got     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (outValid) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    check_eq("done_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [11:0] hold_d;
    logic        hold_o;
    bit          stable;
    int          in0, out0, ntx;
    logic [9:0]  v;
    int          stall;

    rst      = 1'b1;
    binIn    = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_inReady",  32'(inReady),  32'd1);
    check_eq("rst_outValid", 32'(outValid), 32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_digitOut", 32'(digitOut), 32'd0);

    // 555 with outReady held high
    outReady = 1'b1;
    convert(10'h22B, lat);
    check_eq("lat_555",   32'(lat),      32'd11);
    check_eq("bcd_555",   32'(digitOut), 32'h555);
    check_eq("ovf_555",   32'(overflow), 32'd0);
    check_eq("busy_done", 32'(busy),     32'd1);
    check_eq("inReady_done", 32'(inReady), 32'd0);
    tick();
    check_eq("taken_outValid", 32'(outValid), 32'd0);
    check_eq("taken_inReady",  32'(inReady),  32'd1);
    check_eq("taken_busy",     32'(busy),     32'd0);

    // 0 then 999 back to back
    convert(10'd0, lat);
    check_eq("bcd_0", 32'(digitOut), 32'h000);
    check_eq("ovf_0", 32'(overflow), 32'd0);
    tick();
    check_eq("b2b_inReady", 32'(inReady), 32'd1);
    convert(10'd999, lat);
    check_eq("bcd_999", 32'(digitOut), 32'h999);
    check_eq("ovf_999", 32'(overflow), 32'd0);
    check_eq("lat_999", 32'(lat),      32'd11);
    tick();

    // Overflow boundaries
    convert(10'd1000, lat);
    check_eq("bcd_1000", 32'(digitOut), 32'h000);
    check_eq("ovf_1000", 32'(overflow), 32'd1);
    tick();
    convert(10'd1023, lat);
    check_eq("bcd_1023", 32'(digitOut), 32'h023);
    check_eq("ovf_1023", 32'(overflow), 32'd1);
    tick();
    // Overflow flag must clear on the next operand
    convert(10'd7, lat);
    check_eq("bcd_7", 32'(digitOut), 32'h007);
    check_eq("ovf_7", 32'(overflow), 32'd0);
    tick();

    // Long stall in DONE with inValid pulses
    outReady = 1'b0;
    convert(10'd321, lat);
    check_eq("bcd_321", 32'(digitOut), 32'h321);
    hold_d = digitOut;
    hold_o = overflow;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      inValid = c[0];
      binIn   = 10'd5;
      outReady = 1'b0;
      tick();
      if (digitOut !== hold_d || overflow !== hold_o || outValid !== 1'b1 || inReady !== 1'b0)
        stable = 1'b0;
    end
    inValid = 1'b0;
    check_eq("stall_stable", 32'(stable),   32'd1);
    check_eq("stall_bcd",    32'(digitOut), 32'h321);
    outReady = 1'b1;
    tick();
    check_eq("stall_release", 32'(inReady), 32'd1);

    // Reset 5 cycles into SHIFT
    binIn   = 10'd777;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_inReady",  32'(inReady),  32'd1);
    check_eq("abort_outValid", 32'(outValid), 32'd0);
    check_eq("abort_digitOut", 32'(digitOut), 32'd0);
    check_eq("abort_busy_low", 32'(busy),     32'd0);
    convert(10'd42, lat);
    check_eq("bcd_42", 32'(digitOut), 32'h042);
    check_eq("ovf_42", 32'(overflow), 32'd0);
    tick();

    // Random operands with random consumer stalls
    outReady = 1'b0;
    in0 = n_in;
    out0 = n_out;
    ntx = 40;
    for (int t = 0; t < ntx; t++) begin
      v = 10'($urandom_range(0, 1023));
      convert(v, lat);
      check_eq($sformatf("rnd_bcd_%0d", v), 32'(digitOut), 32'(ref_bcd(32'(v))));
      check_eq($sformatf("rnd_ovf_%0d", v), 32'(overflow), 32'(v >= 10'd1000));
      stall  = int'($urandom_range(0, 4));
      hold_d = digitOut;
      stable = 1'b1;
      for (int c = 0; c < stall; c++) begin
        tick();
        if (digitOut !== hold_d || outValid !== 1'b1) stable = 1'b0;
      end
      check_eq("rnd_hold", 32'(stable), 32'd1);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
    end
    tick();
    check_eq("rnd_in_count",  32'(n_in - in0),   32'(ntx));
    check_eq("rnd_out_count", 32'(n_out - out0), 32'(ntx));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
